// File: rtl/doubling_pkg.sv
// Shared types and helpers for the recursive-doubling adder/subtractor family.
// gp_t carries one (generate, propagate) pair; prefix_op is the Kogge-Stone combine.
package doubling_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Combine a higher group with the adjacent lower group.
  function automatic gp_t prefix_op(input gp_t hi, input gp_t lo);
    gp_t o;
    o.g = hi.g | (hi.p & lo.g);
    o.p = hi.p & lo.p;
    return o;
  endfunction

endpackage

// File: rtl/prefix_level.sv
// One combinational Kogge-Stone level: every bit at or above DIST combines with the bit DIST below.
module prefix_level
  import doubling_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  gp_t [WIDTH-1:0] gp_prev,
  output gp_t [WIDTH-1:0] gp_new
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi >= DIST) begin : g_combine
        assign gp_new[gi] = prefix_op(gp_prev[gi], gp_prev[gi-DIST]);
      end else begin : g_pass
        assign gp_new[gi] = gp_prev[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/doubling_subtractor_pipe.sv
// Three-stage pipelined a - b - bin, evaluated as a + ~b + ~bin through a Kogge-Stone prefix network,
// with an elastic valid/ready stream that collapses bubbles and sustains one result per clock.
module doubling_subtractor_pipe
  import doubling_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int LEVELS = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int HALF  = LEVELS / 2;
  localparam int UPPER = LEVELS - HALF;

  logic             s1_v, s2_v, s3_v;
  logic             s1_adv, s2_adv, s3_adv, accept;
  logic [WIDTH-1:0] s1_g, s1_p;
  logic             s1_c0;
  gp_t  [WIDTH-1:0] s2_gp;
  logic [WIDTH-1:0] s2_p;
  logic             s2_c0;
  logic [WIDTH-1:0] s3_diff;
  logic             s3_bout;

  // A stage advances when it holds data and the stage ahead is empty or emptying.
  assign s3_adv   = s3_v & out_ready;
  assign s2_adv   = s2_v & (~s3_v | s3_adv);
  assign s1_adv   = s1_v & (~s2_v | s2_adv);
  assign in_ready = ~s1_v | s1_adv;
  assign accept   = in_valid & in_ready;

  // Carry-in is absorbed into bit 0's generate so carries stay within WIDTH positions.
  gp_t [WIDTH-1:0] fold_gp;
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      fold_gp[i].g = s1_g[i];
      fold_gp[i].p = s1_p[i];
    end
    fold_gp[0].g = s1_g[0] | (s1_p[0] & s1_c0);
  end

  gp_t [WIDTH-1:0] lo_gp [HALF+1];
  gp_t [WIDTH-1:0] hi_gp [UPPER+1];

  assign lo_gp[0] = fold_gp;
  assign hi_gp[0] = s2_gp;

  genvar gi;
  generate
    for (gi = 0; gi < HALF; gi++) begin : g_lo
      prefix_level #(.WIDTH(WIDTH), .DIST(1 << gi)) u_level (
        .gp_prev (lo_gp[gi]),
        .gp_new  (lo_gp[gi+1])
      );
    end
    for (gi = 0; gi < UPPER; gi++) begin : g_hi
      prefix_level #(.WIDTH(WIDTH), .DIST(1 << (HALF + gi))) u_level (
        .gp_prev (hi_gp[gi]),
        .gp_new  (hi_gp[gi+1])
      );
    end
  endgenerate

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] diff_next;
  logic             bout_next;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) carry[i] = hi_gp[UPPER][i].g;
    diff_next[0] = s2_p[0] ^ s2_c0;
    for (int i = 1; i < WIDTH; i++) diff_next[i] = s2_p[i] ^ carry[i-1];
    bout_next = ~carry[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v  <= 1'b0;
      s1_g  <= '0;
      s1_p  <= '0;
      s1_c0 <= 1'b0;
    end else begin
      if (in_ready) s1_v <= in_valid;
      if (accept) begin
        s1_g  <= a & ~b;
        s1_p  <= a ^ ~b;
        s1_c0 <= ~bin;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v  <= 1'b0;
      s2_gp <= '0;
      s2_p  <= '0;
      s2_c0 <= 1'b0;
    end else begin
      if (~s2_v | s2_adv) s2_v <= s1_v;
      if (s1_adv) begin
        s2_gp <= lo_gp[HALF];
        s2_p  <= s1_p;
        s2_c0 <= s1_c0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_v    <= 1'b0;
      s3_diff <= '0;
      s3_bout <= 1'b0;
    end else begin
      if (~s3_v | s3_adv) s3_v <= s2_v;
      if (s2_adv) begin
        s3_diff <= diff_next;
        s3_bout <= bout_next;
      end
    end
  end

  assign out_valid = s3_v;
  assign diff      = s3_diff;
  assign bout      = s3_bout;

endmodule

// File: tb/tb_doubling_subtractor_pipe.sv
// Bench for doubling_subtractor_pipe: directed vector table, reset/backpressure sequences and a
// random valid/ready stream, all checked through a scoreboard of arithmetic reference results.
module tb_doubling_subtractor_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;

  always #5 clk = ~clk;

  doubling_subtractor_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
  );

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
  } vec_t;

  res_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  logic         saw_out;
  logic         accepted;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_diff;
  logic         prev_bout;
  vec_t         vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    res_t r;
    t = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    r.diff = t[W-1:0];
    r.bout = t[W];
    return r;
  endfunction

  function automatic logic [W-1:0] rnd16();
    logic [31:0] r;
    r = $urandom;
    return r[W-1:0];
  endfunction

  // One clock: drive at the falling edge, then observe what the next rising edge will transfer.
  task automatic cycle(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ibin, input logic ordy);
    res_t e;
    @(negedge clk);
    in_valid  = v;
    a         = ia;
    b         = ib;
    bin       = ibin;
    out_ready = ordy;
    #1;
    saw_out  = 1'b0;
    accepted = 1'b0;
    if (prev_stall) begin
      check("stall_hold_valid", 32'(out_valid), 32'(1));
      check("stall_hold_diff", 32'(diff), 32'(prev_diff));
      check("stall_hold_bout", 32'(bout), 32'(prev_bout));
    end
    if (in_valid && in_ready) begin
      sb.push_back(model(ia, ib, ibin));
      accepted = 1'b1;
    end
    if (out_valid && out_ready) begin
      saw_out = 1'b1;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got diff=0x%0h bout=%0d, expected no result", diff, bout);
      end else begin
        e = sb.pop_front();
        check("diff", 32'(diff), 32'(e.diff));
        check("bout", 32'(bout), 32'(e.bout));
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_diff  = diff;
    prev_bout  = bout;
  endtask

  task automatic run_vec(input int idx);
    int   lat;
    logic done;
    vec_t v;
    v = vecs[idx];
    cycle(1'b1, v.a, v.b, v.bin, 1'b1);
    check("vec_accept", 32'(accepted), 32'(1));
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 10) begin
      lat++;
      cycle(1'b0, rnd16(), rnd16(), 1'b0, 1'b1);
      if (saw_out) begin
        done = 1'b1;
        check("vec_diff", 32'(diff), 32'(v.exp_diff));
        check("vec_bout", 32'(bout), 32'(v.exp_bout));
        $display("[TB] vec %0d: a=0x%04h b=0x%04h bin=%0d -> diff=0x%04h bout=%0d latency=%0d",
                 idx, v.a, v.b, v.bin, diff, bout, lat);
      end
    end
    check("vec_latency", 32'(lat), 32'(3));
  endtask

  initial begin
    logic [W-1:0] ba[6];
    logic [W-1:0] bb[6];
    int idx, outs, first_out, last_out, cyc, n_sent, n_recv;
    logic v, ordy;
    logic [W-1:0] ra, rb;
    logic [31:0] sel;

    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{16'h0003, 16'h0003, 1'b0, 16'h0000, 1'b0};
    vecs[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{16'd61560, 16'd60101, 1'b0, 16'd1459, 1'b0};
    vecs[5] = '{16'd5560, 16'd8101, 1'b0, 16'd62995, 1'b1};
    vecs[6] = '{16'h030F, 16'h008B, 1'b0, 16'h0284, 1'b0};
    vecs[7] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1};
    vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};

    // Power-on reset, asserted asynchronously between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'(0));
    check("reset_in_ready", 32'(in_ready), 32'(1));
    check("reset_diff", 32'(diff), 32'(0));
    check("reset_bout", 32'(bout), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i);

    // Reset with two items in flight: nothing may emerge afterwards.
    cycle(1'b1, 16'h1234, 16'h0034, 1'b0, 1'b0);
    cycle(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'(0));
    check("midreset_in_ready", 32'(in_ready), 32'(1));
    sb.delete();
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    outs = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, rnd16(), rnd16(), 1'b0, 1'b1);
      if (saw_out) outs++;
    end
    check("midreset_no_stale", 32'(outs), 32'(0));
    $display("[TB] mid-stream reset: %0d results after release", outs);

    // Backpressure: six items offered while the sink is stalled for eight cycles.
    for (int i = 0; i < 6; i++) begin
      ba[i] = rnd16();
      bb[i] = rnd16();
    end
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(idx < 6, ba[idx % 6], bb[idx % 6], 1'b0, 1'b0);
      if (accepted) idx++;
    end
    check("bp_accepted", 32'(idx), 32'(3));
    check("bp_in_ready", 32'(in_ready), 32'(0));
    outs      = 0;
    first_out = -1;
    last_out  = -1;
    cyc       = 0;
    while (outs < 6 && cyc < 30) begin
      cycle(idx < 6, ba[idx % 6], bb[idx % 6], 1'b0, 1'b1);
      if (accepted) idx++;
      if (saw_out) begin
        if (outs == 0) first_out = cyc;
        last_out = cyc;
        outs++;
        $display("[TB] bp result %0d: diff=0x%04h bout=%0d at cycle %0d", outs, diff, bout, cyc);
      end
      cyc++;
    end
    check("bp_results", 32'(outs), 32'(6));
    check("bp_one_per_clock", 32'(last_out - first_out), 32'(5));

    // Random stream with random handshakes on both sides.
    n_sent = 0;
    n_recv = 0;
    cyc    = 0;
    while (n_recv < 10000 && cyc < 40000) begin
      v    = (n_sent < 10000) && ($urandom_range(3) != 0);
      ordy = ($urandom_range(3) != 0);
      sel  = $urandom_range(7);
      ra   = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : rnd16();
      rb   = (sel == 2) ? 16'h0000 : (sel == 3) ? 16'hFFFF : rnd16();
      cycle(v, ra, rb, $urandom_range(1) == 1, ordy);
      if (accepted) n_sent++;
      if (saw_out) n_recv++;
      cyc++;
    end
    check("rand_received", 32'(n_recv), 32'(10000));
    check("rand_sb_empty", 32'(sb.size()), 32'(0));
    $display("[TB] random stream: %0d sent, %0d received in %0d cycles", n_sent, n_recv, cyc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
